rf_wb_scheduler: RTL and testbench
==================================

Name: rf_wb_scheduler

Overview:
- Sits in front of the 32x32 register file write port in the multicycle core.
- Arbitrates writebacks between two requesters, EXU (ALU/CSR results) and LSU (load data), using valid/ready handshakes and round-robin priority.
- Drives a registered write port into the register file.
- Keeps a per-register pending-write scoreboard, set at issue and cleared at writeback, and flags a read hazard to the IDU for the current source registers.

Parameters:
- NREG, 32, number of architectural registers; scoreboard width.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- exu_valid  input  1  EXU writeback request.
- exu_rd  input  AW  EXU destination register.
- exu_data  input  DW  EXU result.
- exu_ready  output  1  EXU request accepted this cycle.
- lsu_valid  input  1  LSU writeback request.
- lsu_rd  input  AW  LSU destination register.
- lsu_data  input  DW  LSU load data.
- lsu_ready  output  1  LSU request accepted this cycle.
- iss_valid  input  1  IDU issues an instruction that will write iss_rd.
- iss_rd  input  AW  destination of the issued instruction.
- rs1  input  AW  IDU source register 1.
- rs2  input  AW  IDU source register 2.
- hazard  output  1  rs1 or rs2 has a pending write.
- rf_wen  output  1  register file write enable.
- rf_waddr  output  AW  register file write address.
- rf_wdata  output  DW  register file write data.
- busy  output  NREG  scoreboard vector, for debug.

Behaviour:
- Reset, asynchronous and active-high: busy=0, rf_wen=0, rf_waddr=0, rf_wdata=0, round-robin pointer set to EXU-first.
- Reset values of combinational outputs: exu_ready=lsu_ready=0 (no request can be valid at that point); hazard=0 because busy=0.
- Arbitration (combinational, one grant per cycle):
  - If only one requester is valid, it gets ready=1.
  - If both are valid, the pointer decides which one is granted.
  - A handshake completes when valid&ready is high at the clock edge.
- Pointer: after a grant, priority moves to the other requester. With no grant, the pointer holds.
- Requester obligations: once valid rises, rd and data stay stable until accepted. valid may not drop before acceptance.
- Write port latency: exactly 1 cycle after acceptance. The cycle after the handshake, rf_wen=1 and rf_waddr/rf_wdata carry the accepted rd/data. Otherwise rf_wen=0 and addr/data hold their last values.
- x0 writes:
  - The handshake is accepted normally.
  - rf_wen is forced 0 on the following cycle, so x0 is never written.
  - busy[0] is never set.
- Scoreboard:
  - Issue: busy[iss_rd] is set at the edge where iss_valid=1 and iss_rd!=0.
  - Writeback: busy[rd] is cleared at the edge where the write port writes rd, i.e. the rf_wen cycle. The IDU therefore sees the register as free exactly when the register file holds the new value.
- Simultaneous events: an issue and a writeback to the same rd in the same cycle leave busy[rd]=1 (the newer issue wins). Events to different registers apply independently.
- Hazard: hazard = (rs1!=0 & busy[rs1]) | (rs2!=0 & busy[rs2]). It is combinational from current state; no bypass.
- Reset asserted mid-operation: all pending busy bits are lost and any registered write is dropped, so rf_wen goes 0 immediately.
- Back-to-back: one grant per cycle with a continuous handshake stream gives full throughput, one write per cycle.

Test Plan:
- Reset → rf_wen=0, busy=0, hazard=0. Release reset, then EXU valid with rd=5, data=0xDEADBEEF → exu_ready=1 the same cycle; next cycle rf_wen=1, waddr=5, wdata=0xDEADBEEF.
- Both requesters valid for 4 cycles (EXU rd=1..4, LSU rd=11..14, each held until accepted) → grants alternate EXU, LSU, EXU, LSU from reset; write order 1, 11, 2, 12.
- Issue rd=7, then rs1=7 → hazard=1. LSU writeback to 7 is accepted; in the rf_wen cycle busy[7] clears; the following cycle hazard=0.
- Issue rd=9 in the same cycle that rf_wen writes register 9 → busy[9] remains 1 and hazard stays 1 for rs2=9.
- EXU writeback with rd=0, data=0x1234 → exu_ready=1; next cycle rf_wen=0. Issue with rd=0 → busy[0]=0; rs1=0 → hazard=0.
- Asynchronous reset pulse mid-stream, with busy[3]=1 and a write pending → busy=0 and rf_wen=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rf_wb_scheduler.sv
// Writeback arbiter in front of the register file write port: round-robin
// EXU/LSU grant, registered write port and per-register pending-write scoreboard.
module rf_wb_scheduler #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exu_valid,
    input  logic [AW-1:0]   exu_rd,
    input  logic [DW-1:0]   exu_data,
    output logic            exu_ready,
    input  logic            lsu_valid,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [DW-1:0]   lsu_data,
    output logic            lsu_ready,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            hazard,
    output logic            rf_wen,
    output logic [AW-1:0]   rf_waddr,
    output logic [DW-1:0]   rf_wdata,
    output logic [NREG-1:0] busy
);

    logic            lsu_first;
    logic            grant_exu;
    logic            grant_lsu;
    logic            grant_any;
    logic [AW-1:0]   wr_rd;
    logic [DW-1:0]   wr_data;
    logic            wr_go;
    logic [NREG-1:0] busy_nxt;

    // lsu_first=0 means EXU wins a tie; it flips to the other side after each grant.
    assign grant_exu = exu_valid & (~lsu_valid | ~lsu_first);
    assign grant_lsu = lsu_valid & (~exu_valid | lsu_first);
    assign grant_any = grant_exu | grant_lsu;
    assign exu_ready = grant_exu;
    assign lsu_ready = grant_lsu;

    assign wr_rd   = grant_exu ? exu_rd   : lsu_rd;
    assign wr_data = grant_exu ? exu_data : lsu_data;
    assign wr_go   = grant_any && (wr_rd != '0);

    // Issue is applied after writeback so a same-register collision stays busy.
    always_comb begin
        busy_nxt = busy;
        if (rf_wen)
            busy_nxt[rf_waddr] = 1'b0;
        if (iss_valid && (iss_rd != '0))
            busy_nxt[iss_rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lsu_first <= 1'b0;
            rf_wen    <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            busy      <= '0;
        end else begin
            if (grant_any)
                lsu_first <= grant_exu;
            rf_wen <= wr_go;
            if (wr_go) begin
                rf_waddr <= wr_rd;
                rf_wdata <= wr_data;
            end
            busy <= busy_nxt;
        end
    end

    assign hazard = ((rs1 != '0) & busy[rs1]) | ((rs2 != '0) & busy[rs2]);

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: arbitration order, write latency,
// x0 handling, scoreboard set/clear collisions and asynchronous reset.
module tb_rf_wb_scheduler;

    logic        clk;
    logic        rst;
    logic        exu_valid;
    logic [4:0]  exu_rd;
    logic [31:0] exu_data;
    logic        exu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        hazard;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy;

    int n_cmp = 0;
    int n_err = 0;

    rf_wb_scheduler #(.NREG(32), .AW(5), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_ready(exu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2), .hazard(hazard),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [4:0]  exp_addr [4] = '{5'd1, 5'd11, 5'd2, 5'd12};
    logic [31:0] exp_data [4] = '{32'hE000_0001, 32'hA000_000B, 32'hE000_0002, 32'hA000_000C};

    initial begin
        rst = 1'b1;
        exu_valid = 1'b0; exu_rd = '0; exu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        iss_valid = 1'b0; iss_rd = '0; rs1 = '0; rs2 = '0;
        tick();
        tick();
        check("rst_wen", {31'd0, rf_wen}, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_hazard", {31'd0, hazard}, 32'd0);
        check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        check("rst_exu_ready", {31'd0, exu_ready}, 32'd0);
        rst = 1'b0;
        tick();

        // single EXU writeback, one-cycle latency
        exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEAD_BEEF;
        #1;
        check("t1_exu_ready", {31'd0, exu_ready}, 32'd1);
        check("t1_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        check("t1_wen_before", {31'd0, rf_wen}, 32'd0);
        tick();
        exu_valid = 1'b0;
        check("t1_wen", {31'd0, rf_wen}, 32'd1);
        check("t1_waddr", {27'd0, rf_waddr}, 32'd5);
        check("t1_wdata", rf_wdata, 32'hDEAD_BEEF);
        tick();
        check("t1_wen_drop", {31'd0, rf_wen}, 32'd0);
        check("t1_waddr_hold", {27'd0, rf_waddr}, 32'd5);

        // reset pulse between edges to restore EXU-first priority
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        tick();

        // both requesters valid: EXU, LSU, EXU, LSU
        begin
            int ei = 0;
            int li = 0;
            for (int k = 0; k < 4; k++) begin
                exu_valid = 1'b1; exu_rd = 5'(ei + 1); exu_data = 32'hE000_0000 + 32'(ei + 1);
                lsu_valid = 1'b1; lsu_rd = 5'(li + 11); lsu_data = 32'hA000_0000 + 32'(li + 11);
                #1;
                check("t2_exu_ready", {31'd0, exu_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
                check("t2_lsu_ready", {31'd0, lsu_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
                tick();
                check("t2_wen", {31'd0, rf_wen}, 32'd1);
                check("t2_waddr", {27'd0, rf_waddr}, {27'd0, exp_addr[k]});
                check("t2_wdata", rf_wdata, exp_data[k]);
                if (k % 2 == 0) ei++; else li++;
            end
        end
        exu_valid = 1'b0; lsu_valid = 1'b0;
        tick();
        check("t2_idle_wen", {31'd0, rf_wen}, 32'd0);
        check("t2_idle_waddr", {27'd0, rf_waddr}, 32'd12);

        // issue rd=7, then LSU writeback clears it in the rf_wen cycle
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid = 1'b0; rs1 = 5'd7;
        #1;
        check("t3_busy", busy, 32'h0000_0080);
        check("t3_hazard", {31'd0, hazard}, 32'd1);
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h0000_0077;
        #1;
        check("t3_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        tick();
        lsu_valid = 1'b0;
        check("t3_wen", {31'd0, rf_wen}, 32'd1);
        check("t3_hazard_wen_cycle", {31'd0, hazard}, 32'd1);
        tick();
        check("t3_busy_clear", busy, 32'd0);
        check("t3_hazard_clear", {31'd0, hazard}, 32'd0);
        rs1 = 5'd0;

        // issue rd=9 in the same cycle the write port writes 9
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h0000_0099;
        tick();
        lsu_valid = 1'b0;
        check("t4_wen", {31'd0, rf_wen}, 32'd1);
        check("t4_waddr", {27'd0, rf_waddr}, 32'd9);
        iss_valid = 1'b1; iss_rd = 5'd9; rs2 = 5'd9;
        tick();
        iss_valid = 1'b0;
        check("t4_busy_kept", busy, 32'h0000_0200);
        check("t4_hazard", {31'd0, hazard}, 32'd1);
        rs2 = 5'd0;

        // x0 writeback and issue are harmless
        exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'h0000_1234;
        #1;
        check("t5_exu_ready", {31'd0, exu_ready}, 32'd1);
        tick();
        exu_valid = 1'b0;
        check("t5_wen_x0", {31'd0, rf_wen}, 32'd0);
        iss_valid = 1'b1; iss_rd = 5'd0;
        tick();
        iss_valid = 1'b0; rs1 = 5'd0; rs2 = 5'd0;
        #1;
        check("t5_busy0", busy, 32'h0000_0200);
        check("t5_hazard_x0", {31'd0, hazard}, 32'd0);

        // asynchronous reset with busy[3] set and a write in flight
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        iss_valid = 1'b0; rs1 = 5'd3;
        exu_valid = 1'b1; exu_rd = 5'd4; exu_data = 32'h0000_0044;
        tick();
        exu_valid = 1'b0;
        check("t6_wen_pending", {31'd0, rf_wen}, 32'd1);
        check("t6_busy_pre", busy, 32'h0000_0208);
        check("t6_hazard_pre", {31'd0, hazard}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("t6_busy_async", busy, 32'd0);
        check("t6_wen_async", {31'd0, rf_wen}, 32'd0);
        check("t6_hazard_async", {31'd0, hazard}, 32'd0);
        check("t6_waddr_async", {27'd0, rf_waddr}, 32'd0);
        rst = 1'b0;
        tick();
        check("t6_wen_after", {31'd0, rf_wen}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
